plot_sink: RTL

PLOT_SINK -- requirements
Module: plot_sink

---
 rtl/plot_sink.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/plot_sink.sv
// plot_sink -- buffers pixel plot requests in a small FIFO and turns them into
// framebuffer writes for a 160x120, 3-bit-colour screen (address = y*160 + x).
//
// Optional feature: define the macro CLEAR_EN to add the `clear` input and the
// screen-clear sequencer (IDLE -> DRAIN -> CLEAR -> IDLE). Without CLEAR_EN the
// block is a plain plot FIFO that is always idle.
//
// Parameters:
//   DEPTH        plot FIFO depth in entries (power of two, >= 2)
//   CLEAR_COLOUR colour written to every pixel during a screen clear
//
// Ports:
//   clk      in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   plot     in   plot request, accepted when ready is also high
//   x, y     in   10-bit pixel column / row
//   colour   in   3-bit pixel RGB
//   clear    in   (CLEAR_EN only) level-sampled clear request, honoured in IDLE
//   ready    out  request accepted this cycle (FIFO not full and idle)
//   fb_addr  out  15-bit framebuffer write address
//   fb_data  out  3-bit framebuffer write data
//   fb_wren  out  framebuffer write strobe
//   dropped  out  saturating count of rejected and out-of-range requests
module plot_sink #(
  parameter int         DEPTH        = 8,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        plot,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [2:0]  colour,
`ifdef CLEAR_EN
  input  logic        clear,
`endif
  output logic        ready,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_wren,
  output logic [7:0]  dropped
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          EW        = 23;  // {x, y, colour}
  localparam logic [AW:0] PTR_ONE   = 1;
  localparam logic [14:0] LAST_ADDR = 15'd19199;

  // FIFO storage; read asynchronously so the head can be popped and turned
  // into a registered framebuffer write on the same edge.
  logic [EW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic          full, empty, push, pop, can_pop;

  logic [9:0]    head_x, head_y;
  logic [2:0]    head_colour;
  logic          head_in_range;
  logic [14:0]   head_addr;

  logic          fb_wren_reg, fb_wren_next;
  logic [14:0]   fb_addr_reg, fb_addr_next;
  logic [2:0]    fb_data_reg, fb_data_next;
  logic [7:0]    dropped_reg, dropped_next;
  logic [8:0]    dropped_sum;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign push = plot && ready;
  assign pop  = can_pop && !empty;

  assign {head_x, head_y, head_colour} = mem[rd_ptr_reg[AW-1:0]];
  assign head_in_range = (head_x <= 10'd159) && (head_y <= 10'd119);
  // Only meaningful when in range; the product then never exceeds 19199.
  assign head_addr     = (15'(head_y) * 15'd160) + 15'(head_x);

`ifdef CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [14:0] clr_cnt_reg, clr_cnt_next;
  logic        clr_write;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clr_write    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear) state_next = DRAIN;
      end
      DRAIN: begin
        // Wait until the queue is empty and the last pixel write has gone out.
        if (empty && !fb_wren_reg) state_next = CLEAR;
      end
      CLEAR: begin
        // The counter runs one past the last address so that the final clear
        // write is still presented while ready is low; IDLE follows after it.
        if (clr_cnt_reg == LAST_ADDR + 15'd1) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_write    = 1'b1;
          clr_cnt_next = clr_cnt_reg + 15'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign can_pop = (state_reg == IDLE) || (state_reg == DRAIN);
  assign ready   = !full && (state_reg == IDLE);
`else
  assign can_pop = 1'b1;
  assign ready   = !full;

  logic unused_clear_colour;
  assign unused_clear_colour = ^CLEAR_COLOUR;
`endif

  always_comb begin
    fb_wren_next = 1'b0;
    fb_addr_next = fb_addr_reg;
    fb_data_next = fb_data_reg;
    if (pop && head_in_range) begin
      fb_wren_next = 1'b1;
      fb_addr_next = head_addr;
      fb_data_next = head_colour;
    end
`ifdef CLEAR_EN
    else if (clr_write) begin
      fb_wren_next = 1'b1;
      fb_addr_next = clr_cnt_reg;
      fb_data_next = CLEAR_COLOUR;
    end
`endif
  end

  // A rejection and an out-of-range pop can land on the same edge (+2).
  assign dropped_sum  = {1'b0, dropped_reg}
                      + {8'd0, (plot && !ready)}
                      + {8'd0, (pop && !head_in_range)};
  assign dropped_next = dropped_sum[8] ? 8'hFF : dropped_sum[7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {x, y, colour};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      fb_wren_reg <= 1'b0;
      fb_addr_reg <= '0;
      fb_data_reg <= '0;
      dropped_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      fb_wren_reg <= fb_wren_next;
      fb_addr_reg <= fb_addr_next;
      fb_data_reg <= fb_data_next;
      dropped_reg <= dropped_next;
    end
  end

  assign fb_wren = fb_wren_reg;
  assign fb_addr = fb_addr_reg;
  assign fb_data = fb_data_reg;
  assign dropped = dropped_reg;

endmodule
